// File: rtl/display_timer_bcd.sv
// rtl/display_timer_bcd.sv - BCD race-timer text overlay "Time:DDD.F" for the VGA text path
//
// Ports:
//   clk, reset_n (async, active-low)
//   clear, start, stop        : control pulses (clear has priority)
//   refresh_tick              : frame strobe, copies live digits to the display snapshot
//   pix_x, pix_y              : current pixel position
//   time_on                   : pixel inside the timer text field
//   bit_addr, rom_addr        : font ROM column select and {char, glyph row}
//   running, overflow         : state == RUN, sticky max/wrap flag
// Optional build macro TIMER_LAP_EN adds input lap and output lap_hold (lap freeze display).

module display_timer_bcd #(
    parameter int TICK_DIV    = 10000000,
    parameter int INT_DIGITS  = 3,
    parameter int FRAC_DIGITS = 1,
    parameter int TEXT_ROW    = 0,
    parameter int SATURATE    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic        refresh_tick,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
`ifdef TIMER_LAP_EN
    input  logic        lap,
    output logic        lap_hold,
`endif
    output logic        time_on,
    output logic [2:0]  bit_addr,
    output logic [10:0] rom_addr,
    output logic        running,
    output logic        overflow
);

    localparam int N    = INT_DIGITS + FRAC_DIGITS;
    localparam int NCOL = 6 + N;
    localparam int PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    live [N];   // index 0 = least significant fractional digit
    logic [3:0]    snap [N];
    logic [3:0]    inc  [N];
    logic          ripple;
    logic          carry_out;
    logic          tick;

    assign tick = (state == RUN) && (presc == P_LAST);

    // Single-cycle BCD ripple increment of the live digits.
    always_comb begin
        ripple = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (ripple && (live[i] == 4'd9)) begin
                inc[i] = 4'd0;
            end else begin
                inc[i] = live[i] + {3'b000, ripple};
                ripple = 1'b0;
            end
        end
        carry_out = ripple;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            presc    <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < N; i++) live[i] <= 4'd0;
        end else if (clear) begin
            state    <= IDLE;
            presc    <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < N; i++) live[i] <= 4'd0;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (start && !stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick && carry_out && (SATURATE != 0)) begin
                        // Digits are left at all-9s; only clear leaves SAT.
                        state    <= SAT;
                        running  <= 1'b0;
                        overflow <= 1'b1;
                    end else begin
                        // The wrapped increment of all-9s is already all-0s.
                        if (tick) begin
                            for (int i = 0; i < N; i++) live[i] <= inc[i];
                            if (carry_out) overflow <= 1'b1;
                        end
                        if (stop && !start) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TIMER_LAP_EN
    logic [3:0] lap_reg [N];
    logic [6:0] lap_cnt;   // refresh_ticks left showing the lap value

    assign lap_hold = (lap_cnt != 7'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_cnt <= 7'd0;
            for (int i = 0; i < N; i++) lap_reg[i] <= 4'd0;
        end else if (clear) begin
            lap_cnt <= 7'd0;
        end else if (lap && (state == RUN)) begin
            lap_cnt <= 7'd120;
            for (int i = 0; i < N; i++) lap_reg[i] <= live[i];
        end else if (refresh_tick && lap_hold) begin
            lap_cnt <= lap_cnt - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) snap[i] <= 4'd0;
        end else if (refresh_tick) begin
            for (int i = 0; i < N; i++) snap[i] <= lap_hold ? lap_reg[i] : live[i];
        end
    end
`else
    // Snapshot is deliberately untouched by clear so a frame never shows a partial reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) snap[i] <= 4'd0;
        end else if (refresh_tick) begin
            for (int i = 0; i < N; i++) snap[i] <= live[i];
        end
    end
`endif

    // Combinational pixel path.
    logic [5:0] col;
    logic [6:0] char_addr;
    logic       lead;
    logic       unused_pix;

    assign col        = pix_x[9:4];
    assign unused_pix = &{1'b0, pix_x[0], pix_y[0]};

    always_comb begin
        char_addr = 7'h00;
        lead      = 1'b1;
        case (col)
            6'd0: char_addr = 7'h54;
            6'd1: char_addr = 7'h69;
            6'd2: char_addr = 7'h6D;
            6'd3: char_addr = 7'h65;
            6'd4: char_addr = 7'h3A;
            default: ;
        endcase
        // lead stays set while every integer digit from the MS one down is zero;
        // the units digit always prints.
        for (int k = 0; k < INT_DIGITS; k++) begin
            lead = lead && (snap[N-1-k] == 4'd0) && (k != INT_DIGITS - 1);
            if (col == 6'(5 + k)) char_addr = lead ? 7'h20 : {3'b011, snap[N-1-k]};
        end
        if (col == 6'(5 + INT_DIGITS)) char_addr = 7'h2E;
        for (int f = 0; f < FRAC_DIGITS; f++) begin
            if (col == 6'(6 + INT_DIGITS + f)) char_addr = {3'b011, snap[FRAC_DIGITS-1-f]};
        end
    end

    assign time_on  = (pix_y[9:5] == 5'(TEXT_ROW)) && (col < 6'(NCOL));
    assign bit_addr = pix_x[3:1] - 3'd1;
    assign rom_addr = {char_addr, pix_y[4:1]};

endmodule

// File: tb/tb_display_timer_bcd.sv
// tb/tb_display_timer_bcd.sv - directed self-checking bench for display_timer_bcd

module tb_display_timer_bcd;

    logic        clk;
    logic        reset_n;
    logic        refresh_tick;
    logic [2:0]  clr, sta, sto;
    logic [9:0]  pix_x, pix_y;
    logic [2:0]  ton, run, ovf;
    logic [2:0]  bad [3];
    logic [10:0] rom [3];
`ifdef TIMER_LAP_EN
    logic        lap_a;
    logic [2:0]  lhold;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // inst 0: main timer, inst 1: saturating 1.1 timer, inst 2: wrapping 1.1 timer
    display_timer_bcd #(.TICK_DIV(4), .INT_DIGITS(3), .FRAC_DIGITS(1), .TEXT_ROW(2), .SATURATE(1)) u_a (
        .clk(clk), .reset_n(reset_n), .clear(clr[0]), .start(sta[0]), .stop(sto[0]),
        .refresh_tick(refresh_tick), .pix_x(pix_x), .pix_y(pix_y),
`ifdef TIMER_LAP_EN
        .lap(lap_a), .lap_hold(lhold[0]),
`endif
        .time_on(ton[0]), .bit_addr(bad[0]), .rom_addr(rom[0]), .running(run[0]), .overflow(ovf[0]));

    display_timer_bcd #(.TICK_DIV(2), .INT_DIGITS(1), .FRAC_DIGITS(1), .TEXT_ROW(2), .SATURATE(1)) u_s (
        .clk(clk), .reset_n(reset_n), .clear(clr[1]), .start(sta[1]), .stop(sto[1]),
        .refresh_tick(refresh_tick), .pix_x(pix_x), .pix_y(pix_y),
`ifdef TIMER_LAP_EN
        .lap(1'b0), .lap_hold(lhold[1]),
`endif
        .time_on(ton[1]), .bit_addr(bad[1]), .rom_addr(rom[1]), .running(run[1]), .overflow(ovf[1]));

    display_timer_bcd #(.TICK_DIV(2), .INT_DIGITS(1), .FRAC_DIGITS(1), .TEXT_ROW(2), .SATURATE(0)) u_w (
        .clk(clk), .reset_n(reset_n), .clear(clr[2]), .start(sta[2]), .stop(sto[2]),
        .refresh_tick(refresh_tick), .pix_x(pix_x), .pix_y(pix_y),
`ifdef TIMER_LAP_EN
        .lap(1'b0), .lap_hold(lhold[2]),
`endif
        .time_on(ton[2]), .bit_addr(bad[2]), .rom_addr(rom[2]), .running(run[2]), .overflow(ovf[2]));

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each control pulse occupies exactly one rising edge; caller sits at a negedge.
    task automatic ctl(input int inst, input logic c, input logic s, input logic p);
        clr[inst] = c; sta[inst] = s; sto[inst] = p;
        @(negedge clk);
        clr[inst] = 1'b0; sta[inst] = 1'b0; sto[inst] = 1'b0;
    endtask

    task automatic refresh();
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
    endtask

    task automatic chk_char(input string tag, input int inst, input int col, input logic [6:0] exp);
        pix_x = 10'(col * 16 + 2);
        pix_y = 10'd70;
        #1;
        check(tag, 32'(rom[inst][10:4]), 32'(exp));
    endtask

    initial begin
        reset_n = 1'b0; refresh_tick = 1'b0;
        clr = '0; sta = '0; sto = '0;
        pix_x = '0; pix_y = '0;
`ifdef TIMER_LAP_EN
        lap_a = 1'b0;
`endif
        step(3);
        reset_n = 1'b1;

        // Reset state and static text
        check("rst_running", 32'(run[0]), 32'd0);
        check("rst_overflow", 32'(ovf[0]), 32'd0);
        chk_char("rst_col0_T", 0, 0, 7'h54);
        chk_char("rst_col4_colon", 0, 4, 7'h3A);
        chk_char("rst_col6_blank", 0, 6, 7'h20);
        chk_char("rst_col7_zero", 0, 7, 7'h30);
        chk_char("rst_col8_dot", 0, 8, 7'h2E);
        chk_char("rst_col9_zero", 0, 9, 7'h30);
        pix_x = 10'd146; pix_y = 10'd70; #1;
        check("time_on_col9", 32'(ton[0]), 32'd1);
        check("bit_addr_x146", 32'(bad[0]), 32'd0);
        pix_x = 10'd160; #1;
        check("time_on_col10", 32'(ton[0]), 32'd0);
        check("col10_null", 32'(rom[0][10:4]), 32'h00);
        check("bit_addr_x160", 32'(bad[0]), 32'd7);
        pix_x = 10'd2; pix_y = 10'd40; #1;
        check("time_on_row1", 32'(ton[0]), 32'd0);

        // 40 cycles at TICK_DIV=4 -> 001.0
        ctl(0, 1'b0, 1'b1, 1'b0);
        check("start_running", 32'(run[0]), 32'd1);
        step(40);
        refresh();
        chk_char("t40_col5", 0, 5, 7'h20);
        check("t40_rom5", 32'(rom[0]), 32'({7'h20, 4'd3}));
        chk_char("t40_col7", 0, 7, 7'h31);
        check("t40_rom7", 32'(rom[0]), 32'({7'h31, 4'd3}));
        chk_char("t40_col9", 0, 9, 7'h30);

        // Pause: prescaler was at 2 when stop landed
        ctl(0, 1'b0, 1'b0, 1'b1);
        check("stop_running", 32'(run[0]), 32'd0);
        step(100);
        refresh();
        chk_char("pause_col9", 0, 9, 7'h30);
        ctl(0, 1'b0, 1'b1, 1'b0);
        check("resume_running", 32'(run[0]), 32'd1);
        step(1);
        refresh();
        chk_char("resume_hold_col9", 0, 9, 7'h30);
        refresh();
        chk_char("resume_inc_col9", 0, 9, 7'h31);

        // clear leaves the snapshot alone until the next refresh
        ctl(0, 1'b1, 1'b0, 1'b0);
        check("clear_running", 32'(run[0]), 32'd0);
        chk_char("clear_keeps_snap", 0, 9, 7'h31);

        // 099.9 -> 100.0
        ctl(0, 1'b0, 1'b1, 1'b0);
        step(3996);
        refresh();
        chk_char("n999_col5", 0, 5, 7'h20);
        chk_char("n999_col6", 0, 6, 7'h39);
        chk_char("n999_col7", 0, 7, 7'h39);
        chk_char("n999_col9", 0, 9, 7'h39);
        step(3);
        refresh();
        chk_char("n1000_col5", 0, 5, 7'h31);
        chk_char("n1000_col6", 0, 6, 7'h30);
        chk_char("n1000_col7", 0, 7, 7'h30);
        chk_char("n1000_col9", 0, 9, 7'h30);
        check("n1000_overflow", 32'(ovf[0]), 32'd0);

        // Saturating 9.9 timer
        ctl(1, 1'b0, 1'b1, 1'b0);
        step(210);
        check("sat_running", 32'(run[1]), 32'd0);
        check("sat_overflow", 32'(ovf[1]), 32'd1);
        refresh();
        chk_char("sat_col5", 1, 5, 7'h39);
        chk_char("sat_col6_dot", 1, 6, 7'h2E);
        chk_char("sat_col7", 1, 7, 7'h39);
        chk_char("sat_col8_null", 1, 8, 7'h00);
        check("sat_time_on_col8", 32'(ton[1]), 32'd0);
        ctl(1, 1'b0, 1'b1, 1'b0);
        step(5);
        check("sat_start_ignored", 32'(run[1]), 32'd0);
        ctl(1, 1'b1, 1'b0, 1'b0);
        check("sat_clear_overflow", 32'(ovf[1]), 32'd0);
        check("sat_clear_running", 32'(run[1]), 32'd0);
        refresh();
        chk_char("sat_clear_col5", 1, 5, 7'h30);
        chk_char("sat_clear_col7", 1, 7, 7'h30);

        // Wrapping 9.9 timer
        ctl(2, 1'b0, 1'b1, 1'b0);
        step(198);
        check("wrap_pre_overflow", 32'(ovf[2]), 32'd0);
        step(2);
        check("wrap_overflow", 32'(ovf[2]), 32'd1);
        check("wrap_running", 32'(run[2]), 32'd1);
        refresh();
        chk_char("wrap_col5", 2, 5, 7'h30);
        chk_char("wrap_col7", 2, 7, 7'h30);
        ctl(2, 1'b0, 1'b1, 1'b1);
        check("both_in_run", 32'(run[2]), 32'd1);
        ctl(2, 1'b0, 1'b0, 1'b1);
        check("wrap_stop", 32'(run[2]), 32'd0);
        ctl(2, 1'b0, 1'b1, 1'b1);
        check("both_in_pause", 32'(run[2]), 32'd0);
        ctl(2, 1'b0, 1'b1, 1'b0);
        check("wrap_resume", 32'(run[2]), 32'd1);

`ifdef TIMER_LAP_EN
        // Lap at 005.3, held for 120 frames
        ctl(0, 1'b1, 1'b0, 1'b0);
        ctl(0, 1'b0, 1'b1, 1'b0);
        step(212);
        lap_a = 1'b1;
        @(negedge clk);
        lap_a = 1'b0;
        check("lap_hold_set", 32'(lhold[0]), 32'd1);
        for (int i = 0; i < 120; i++) begin
            refresh();
            if (i == 0) begin
                chk_char("lap_col7", 0, 7, 7'h35);
                chk_char("lap_col9", 0, 9, 7'h33);
            end
            if (i == 118) check("lap_hold_119", 32'(lhold[0]), 32'd1);
        end
        check("lap_hold_done", 32'(lhold[0]), 32'd0);
        chk_char("lap_last_col9", 0, 9, 7'h33);
        refresh();
        chk_char("lap_live_col7", 0, 7, 7'h38);
        chk_char("lap_live_col9", 0, 9, 7'h33);
`endif

        // Async reset off a clock edge while running
        ctl(0, 1'b1, 1'b0, 1'b0);
        ctl(0, 1'b0, 1'b1, 1'b0);
        step(50);
        refresh();
        chk_char("pre_rst_col7", 0, 7, 7'h31);
        chk_char("pre_rst_col9", 0, 9, 7'h32);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_running", 32'(run[0]), 32'd0);
        check("async_rst_running_w", 32'(run[2]), 32'd0);
        chk_char("async_rst_col7", 0, 7, 7'h30);
        chk_char("async_rst_col9", 0, 9, 7'h30);
        @(negedge clk);
        reset_n = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_timer_bcd.md
Name: display_timer_bcd

Overview:
Parametrised race-timer overlay for the VGA text path. Holds a BCD elapsed-time counter with an explicit run/pause/clear state machine and a per-frame display snapshot. Generates font-ROM character addresses for one text row "Time:DDD.F", with configurable digit counts and leading-zero blanking. Feeds the shared font ROM and pixel mux alongside the other text overlays.

Parameters:
TICK_DIV, 10000000, clk cycles per least-significant fractional-digit increment (>=2)
INT_DIGITS, 3, integer digits shown (1..4)
FRAC_DIGITS, 1, fractional digits shown (1..2)
TEXT_ROW, 0, 32-px text row index (pix_y[9:5]) where the timer is drawn
SATURATE, 1, 1 = stop at all-9s; 0 = wrap to zero

Ports:
clk  in  1  pixel/system clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  sync clear to zero, returns to IDLE
start  in  1  single-cycle pulse: begin/resume counting
stop  in  1  single-cycle pulse: pause counting
refresh_tick  in  1  one-cycle frame strobe; display snapshot update
pix_x  in  10  current pixel column
pix_y  in  10  current pixel row
time_on  out  1  pixel lies inside timer text field
bit_addr  out  3  font column select, pix_x[3:1]-1
rom_addr  out  11  {char_addr[6:0], pix_y[4:1]}
running  out  1  state == RUN
overflow  out  1  sticky: counter hit max (SATURATE=1) or wrapped (SATURATE=0)

Behaviour:
- Reset (reset_n low, async): state IDLE, all live and snapshot digits 0, prescaler 0, running 0, overflow 0. Outputs time_on/bit_addr/rom_addr remain combinational from pix_x/pix_y.
- Digits: N = INT_DIGITS+FRAC_DIGITS BCD nibbles, LS = last fractional digit. No division/modulo anywhere.
- Prescaler: counts 0..TICK_DIV-1 only in RUN; holds in PAUSE/SAT; zeroed by clear. Terminal count -> one increment pulse, prescaler -> 0.
- Increment: single-cycle ripple; each nibble 9 -> 0 with carry. Carry out of the MS nibble: SATURATE=1 -> all nibbles stay 9, overflow=1, state SAT; SATURATE=0 -> all nibbles 0, overflow=1, stay RUN.
- FSM: IDLE -start-> RUN; RUN -stop-> PAUSE; PAUSE -start-> RUN; RUN -max reached-> SAT. clear from any state -> IDLE next cycle (digits, prescaler, overflow zeroed). SAT exits only via clear.
- Priority: clear > everything. start and stop asserted together: no state change. start in RUN, stop in IDLE/PAUSE/SAT: ignored.
- Increment pulse coinciding with stop: increment applied, then PAUSE.
- Snapshot: on refresh_tick, copy live digits into display registers; ones and tens are therefore never torn within a frame. clear does not touch the snapshot; the next refresh_tick shows zero.
- Text field: NCOL = 5+INT_DIGITS+1+FRAC_DIGITS chars, 16 px wide. time_on = (pix_y[9:5]==TEXT_ROW) && (pix_x[9:4] < NCOL).
- Columns: 0..4 = 'T' 0x54, 'i' 0x69, 'm' 0x6D, 'e' 0x65, ':' 0x3A; then integer digits MS first; then '.' 0x2E; then fractional digits; beyond NCOL -> 0x00.
- Digit char = {3'b011, nibble}. Leading-zero blanking: integer digits above the highest nonzero one print space 0x20; the units digit and fractional digits always print.
- Pixel path is fully combinational (zero latency), matching the other overlays.

Optional Feature:
TIMER_LAP_EN: adds input lap (1 bit, one-cycle pulse) and output lap_hold (1). When lap is asserted in RUN, live digits are copied into a lap register and lap_hold=1 for 120 refresh_ticks. While lap_hold=1 the snapshot shows the lap register; counting continues underneath. A further lap restarts the hold. clear drops lap_hold. Without the macro: no lap port, no lap_hold port, no lap logic; the snapshot always follows the live digits.

Test Plan:
- Reset, TICK_DIV=4, start, 40 cycles, refresh_tick -> snapshot 001.0 displays as "  1.0", with rom_addr at column 5 = {0x20, row}; at column 7 = {0x31, row}.
- Run to 099.9, next increment -> 100.0; column 5 char 0x31, column 6 0x30.
- stop after 10 cycles, idle 100 cycles, start -> count frozen while paused, prescaler resumes from its held value, running follows the state.
- SATURATE=1, preload near 999.9, run -> holds 999.9, overflow=1, state SAT; start ignored; clear -> 000.0, IDLE, overflow=0.
- SATURATE=0, same run -> wraps to 000.0, overflow=1, running=1. Also start+stop same cycle -> no state change.
- Drop reset_n mid-RUN off a clock edge -> all state zero immediately; with TIMER_LAP_EN, lap at 005.3 then refresh_ticks -> 005.3 shown for 120 frames, then live value shown.
